alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ARM-style data-processing ALU with an iterative shift-add multiplier.
// Ports: valid/ready request (op, mul, a, b, acc, cin) -> result, n z c v, wb.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             wb
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0] mp_q, mp_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mcin_q, mcin_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             wb_q, wb_d;

  logic [WIDTH-1:0] ax, ay;
  logic             aci;
  logic             arith;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic             accept, mul_go;

  assign in_ready  = (state_q == IDLE) ||
                     ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_go    = MUL_EN && mul;

  assign result = result_q;
  assign n      = n_q;
  assign z      = z_q;
  assign c      = c_q;
  assign v      = v_q;
  assign wb     = wb_q;

  // Every arithmetic op is folded onto one adder: x + y + carry-in,
  // with subtraction as x + ~y + 1 (or + cin for the carry variants).
  always_comb begin
    ax    = a;
    ay    = b;
    aci   = 1'b0;
    arith = 1'b1;
    unique case (op)
      4'h2, 4'hA: begin ay = ~b; aci = 1'b1; end
      4'h3:       begin ax = b; ay = ~a; aci = 1'b1; end
      4'h4, 4'hB: begin end
      4'h5:       aci = cin;
      4'h6:       begin ay = ~b; aci = cin; end
      4'h7:       begin ax = b; ay = ~a; aci = cin; end
      default:    arith = 1'b0;
    endcase
    sum = {1'b0, ax} + {1'b0, ay} + {{WIDTH{1'b0}}, aci};
    alu_res = sum[WIDTH-1:0];
    alu_c   = cin;
    alu_v   = 1'b0;
    if (arith) begin
      alu_c = sum[WIDTH];
      alu_v = (ax[WIDTH-1] == ay[WIDTH-1]) &&
              (sum[WIDTH-1] != ax[WIDTH-1]);
    end else begin
      unique case (op)
        4'h0, 4'h8: alu_res = a & b;
        4'h1, 4'h9: alu_res = a ^ b;
        4'hC:       alu_res = a | b;
        4'hD:       alu_res = b;
        4'hE:       alu_res = a & ~b;
        4'hF:       alu_res = ~b;
        default:    alu_res = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    mcin_d   = mcin_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    wb_d     = wb_q;
    unique case (state_q)
      BUSY: begin
        // cnt counts completed iterations; the extra cycle at LAST
        // publishes the product and its flags.
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = prod_q;
          n_d      = prod_q[WIDTH-1];
          z_d      = (prod_q == '0);
          c_d      = mcin_q;
          v_d      = 1'b0;
          wb_d     = 1'b1;
        end else begin
          prod_d = mp_q[0] ? prod_q + mc_q : prod_q;
          mc_d   = mc_q << 1;
          mp_d   = mp_q >> 1;
          cnt_d  = cnt_q + ONE;
        end
      end
      default: begin
        if ((state_q == DONE) && out_ready) state_d = IDLE;
        if (accept) begin
          if (mul_go) begin
            state_d = BUSY;
            mc_d    = a;
            mp_d    = b;
            prod_d  = op[0] ? acc : '0;
            cnt_d   = '0;
            mcin_d  = cin;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            n_d      = alu_res[WIDTH-1];
            z_d      = (alu_res == '0);
            c_d      = alu_c;
            v_d      = alu_v;
            wb_d     = (op[3:2] != 2'b10);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mc_q     <= '0;
      mp_q     <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      mcin_q   <= 1'b0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      wb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      mcin_q   <= mcin_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      wb_q     <= wb_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32).
// Expected values are hand-computed constants.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        mul;
  logic [31:0] a, b, acc;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        n, z, c, v, wb;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [37:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .mul(mul), .a(a), .b(b), .acc(acc), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .n(n), .z(z), .c(c), .v(v), .wb(wb)
  );

  function automatic logic [37:0] obs();
    return {out_valid, result, n, z, c, v, wb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then scramble the inputs.
  task automatic send(input logic [3:0] o, input logic m,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ac, input logic ci);
    in_valid = 1'b1;
    op = o; mul = m; a = x; b = y; acc = ac; cin = ci;
    tick();
    in_valid = 1'b0;
    op = 4'($urandom); mul = 1'($urandom);
    a = $urandom; b = $urandom; acc = $urandom; cin = 1'($urandom);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; op = 0; mul = 0; a = 0; b = 0; acc = 0; cin = 0;
    out_ready = 0;
    tick(); tick();
    tests++;
    if (obs() !== 38'd0) begin
      fails++;
      $display("FAIL reset_state got %h exp %h", obs(), 38'd0);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic run_table(input string name, input vec_t tv[$]);
    for (int i = 0; i < tv.size(); i++) begin
      send(tv[i].op, 1'b0, tv[i].a, tv[i].b, 32'd0, tv[i].cin);
      tests++;
      if (obs() !== tv[i].exp) begin
        fails++;
        $display("FAIL %s[%0d] got %h exp %h", name, i, obs(),
                 tv[i].exp);
      end
      drain();
    end
  endtask

  task automatic test_arith();
    vec_t tv[$];
    tv.push_back('{4'h4, 32'd25, 32'd20, 1'b1,
                   {1'b1, 32'd45, 5'b00001}});
    tv.push_back('{4'h2, 32'd20, 32'd25, 1'b0,
                   {1'b1, 32'hFFFFFFFB, 5'b10001}});
    tv.push_back('{4'hA, 32'd25, 32'd25, 1'b0,
                   {1'b1, 32'd0, 5'b01100}});
    tv.push_back('{4'h4, 32'h7FFFFFFF, 32'd1, 1'b0,
                   {1'b1, 32'h80000000, 5'b10011}});
    tv.push_back('{4'h5, 32'hFFFFFFFF, 32'd0, 1'b1,
                   {1'b1, 32'd0, 5'b01101}});
    tv.push_back('{4'h3, 32'd5, 32'd3, 1'b0,
                   {1'b1, 32'hFFFFFFFE, 5'b10001}});
    tv.push_back('{4'h6, 32'd10, 32'd3, 1'b0,
                   {1'b1, 32'd6, 5'b00101}});
    tv.push_back('{4'h7, 32'd3, 32'd10, 1'b1,
                   {1'b1, 32'd7, 5'b00101}});
    tv.push_back('{4'hB, 32'hFFFFFFFF, 32'd1, 1'b0,
                   {1'b1, 32'd0, 5'b01100}});
    tv.push_back('{4'h2, 32'h80000000, 32'd1, 1'b0,
                   {1'b1, 32'h7FFFFFFF, 5'b00111}});
    run_table("arith", tv);
  endtask

  task automatic test_logic();
    vec_t tv[$];
    tv.push_back('{4'h0, 32'hF0F0, 32'hFF00, 1'b1,
                   {1'b1, 32'hF000, 5'b00101}});
    tv.push_back('{4'hC, 32'h0F, 32'hF0, 1'b0,
                   {1'b1, 32'hFF, 5'b00001}});
    tv.push_back('{4'hD, 32'd5, 32'd0, 1'b0,
                   {1'b1, 32'd0, 5'b01001}});
    tv.push_back('{4'hF, 32'd5, 32'd0, 1'b1,
                   {1'b1, 32'hFFFFFFFF, 5'b10101}});
    tv.push_back('{4'hE, 32'hFF, 32'h0F, 1'b0,
                   {1'b1, 32'hF0, 5'b00001}});
    tv.push_back('{4'h8, 32'hF0, 32'h0F, 1'b1,
                   {1'b1, 32'd0, 5'b01100}});
    tv.push_back('{4'h9, 32'd5, 32'd5, 1'b0,
                   {1'b1, 32'd0, 5'b01000}});
    tv.push_back('{4'h9, 32'd1, 32'h80000000, 1'b0,
                   {1'b1, 32'h80000001, 5'b10000}});
    run_table("logic", tv);
  endtask

  task automatic test_mul();
    int bad;
    int seen;
    send(4'hF, 1'b1, 32'd7, 32'd6, 32'd3, 1'b0);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mla_busy got %0d bad cycles exp 0", bad);
    end
    tick();
    tests++;
    if (obs() !== {1'b1, 32'd45, 5'b00001}) begin
      fails++;
      $display("FAIL mla_cycle33 got %h exp %h", obs(),
               {1'b1, 32'd45, 5'b00001});
    end
    drain();
    send(4'h2, 1'b1, 32'h10000, 32'h10000, 32'h55, 1'b1);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (out_valid === 1'b1) seen = 1;
    end
    tests++;
    if (obs() !== {1'b1, 32'd0, 5'b01101}) begin
      fails++;
      $display("FAIL mul_overflow got %h exp %h", obs(),
               {1'b1, 32'd0, 5'b01101});
    end
    drain();
    send(4'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 1'b0);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (out_valid === 1'b1) seen = 1;
    end
    tests++;
    if (obs() !== {1'b1, 32'd1, 5'b00001}) begin
      fails++;
      $display("FAIL mul_ones got %h exp %h", obs(),
               {1'b1, 32'd1, 5'b00001});
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int bad;
    send(4'h1, 1'b0, 32'hF0, 32'hFF, 32'd0, 1'b0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (obs() !== {1'b1, 32'h0F, 5'b00001} || in_ready !== 1'b0)
        bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hold_stable got %0d bad cycles exp 0", bad);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 4'h4; mul = 1'b0; a = 32'd1; b = 32'd2; cin = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready got %b exp 1", in_ready);
    end
    tick();
    tests++;
    if (obs() !== {1'b1, 32'd3, 5'b00001}) begin
      fails++;
      $display("FAIL b2b_first got %h exp %h", obs(),
               {1'b1, 32'd3, 5'b00001});
    end
    op = 4'h2; a = 32'd10; b = 32'd4;
    tick();
    in_valid = 1'b0;
    tests++;
    if (obs() !== {1'b1, 32'd6, 5'b00101}) begin
      fails++;
      $display("FAIL b2b_second got %h exp %h", obs(),
               {1'b1, 32'd6, 5'b00101});
    end
    tick();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle got %b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_busy();
    int bad;
    send(4'h0, 1'b1, 32'd3, 32'd5, 32'd0, 1'b1);
    for (int k = 1; k < 10; k++) tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs() !== 38'd0) begin
      fails++;
      $display("FAIL reset_busy got %h exp %h", obs(), 38'd0);
    end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stale_mul got %0d valid cycles exp 0", bad);
    end
    send(4'h4, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0);
    tests++;
    if (obs() !== {1'b1, 32'd2, 5'b00001}) begin
      fails++;
      $display("FAIL post_reset_add got %h exp %h", obs(),
               {1'b1, 32'd2, 5'b00001});
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_mul();
    test_back_to_back();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
